// File: rtl/load_wb_unit_if.sv
// Request and memory-bus signals for the load write-back unit.
// The slave modport is the unit; the master modport drives it as core and memory.
interface load_wb_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [4:0]  req_rd;
    logic [2:0]  req_funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_addr, req_rd, req_funct3,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, mem_req, mem_addr
    );

    modport slave (
        input  req_valid, req_addr, req_rd, req_funct3,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, mem_req, mem_addr
    );
endinterface

// File: rtl/load_wb_unit.sv
// Load unit: checks the request, reads one word, extends the selected
// byte/half/word and writes it back to the register file.
module load_wb_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    load_wb_unit_if.slave bus,
    output logic [4:0]    waddr,
    output logic          we3,
    output logic [31:0]   wd3,
    output logic          err,
    output logic          busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [7:0]  cnt;
    logic [31:0] maddr_q;

    logic        hs;
    logic        legal;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext;

    assign hs = bus.req_valid && (state == IDLE);

    always_comb begin
        legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~bus.req_addr[0];
            3'b010:         legal = (bus.req_addr[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase
    end

    assign byte_sel = bus.mem_rdata[{off_q, 3'b000} +: 8];
    assign half_sel = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        ext = bus.mem_rdata;
        unique case (1'b1)
            f3_q == 3'b000: ext = {{24{byte_sel[7]}}, byte_sel};
            f3_q == 3'b100: ext = {24'h0, byte_sel};
            f3_q == 3'b001: ext = {{16{half_sel[15]}}, half_sel};
            f3_q == 3'b101: ext = {16'h0, half_sel};
            default:        ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            off_q   <= 2'b00;
            rd_q    <= 5'd0;
            f3_q    <= 3'b000;
            cnt     <= 8'd0;
            maddr_q <= 32'h0;
            waddr   <= 5'd0;
            wd3     <= 32'h0;
            we3     <= 1'b0;
            err     <= 1'b0;
        end else begin
            we3 <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        if (legal) begin
                            state   <= REQ;
                            off_q   <= bus.req_addr[1:0];
                            rd_q    <= bus.req_rd;
                            f3_q    <= bus.req_funct3;
                            maddr_q <= {bus.req_addr[31:2], 2'b00};
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        state <= WAIT;
                        cnt   <= 8'd0;
                    end
                end
                WAIT: begin
                    // rvalid on the last counted cycle still wins
                    if (bus.mem_rvalid) begin
                        state <= WB;
                        if (rd_q != 5'd0) begin
                            we3   <= 1'b1;
                            waddr <= rd_q;
                            wd3   <= ext;
                        end
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_req   = (state == REQ);
    assign bus.mem_addr  = maddr_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_load_wb_unit.sv
// Directed bench for load_wb_unit: vector table plus hand-written
// sequences for grant stall, timeout and reset in WAIT.
module tb_load_wb_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  waddr;
    logic        we3;
    logic [31:0] wd3;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    load_wb_unit_if bus ();

    load_wb_unit #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .waddr (waddr),
        .we3   (we3),
        .wd3   (wd3),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        bad;
        logic [31:0] maddr;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            n_checks++;
            if (we3 === 1'b1 && err === 1'b1) begin
                n_fail++;
                $display("FAIL we3_err_overlap: got 1, expected 0");
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        chk({s, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_addr   = v.addr;
        bus.req_rd     = v.rd;
        bus.req_funct3 = v.f3;
        step();
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'hFFFF_FFFF;
        if (v.bad) begin
            chk({s, "_err"}, 32'(err), 32'd1);
            chk({s, "_memreq"}, 32'(bus.mem_req), 32'd0);
            chk({s, "_ready_hold"}, 32'(bus.req_ready), 32'd1);
            chk({s, "_we3"}, 32'(we3), 32'd0);
            step();
            chk({s, "_err_end"}, 32'(err), 32'd0);
        end else begin
            chk({s, "_memreq"}, 32'(bus.mem_req), 32'd1);
            chk({s, "_maddr"}, bus.mem_addr, v.maddr);
            bus.mem_gnt = 1'b1;
            step();
            bus.mem_gnt    = 1'b0;
            chk({s, "_wait_busy"}, 32'(busy), 32'd1);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = v.rdata;
            step();
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'hA5A5_5A5A;
            chk({s, "_we3"}, 32'(we3), 32'(v.rd != 5'd0));
            if (v.rd != 5'd0) begin
                chk({s, "_waddr"}, 32'(waddr), 32'(v.rd));
                chk({s, "_wd3"}, wd3, v.wd);
            end
            chk({s, "_err"}, 32'(err), 32'd0);
            step();
            chk({s, "_we3_end"}, 32'(we3), 32'd0);
            chk({s, "_busy_end"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'h0000_0103, 5'd5,  32'h80FF_1234, 1'b0, 32'h0000_0100, 32'hFFFF_FF80};
        vecs[1]  = '{3'b101, 32'h0000_0202, 5'd7,  32'h9ABC_0000, 1'b0, 32'h0000_0200, 32'h0000_9ABC};
        vecs[2]  = '{3'b001, 32'h0000_0202, 5'd7,  32'h9ABC_0000, 1'b0, 32'h0000_0200, 32'hFFFF_9ABC};
        vecs[3]  = '{3'b010, 32'h0000_0006, 5'd4,  32'h0,         1'b1, 32'h0,         32'h0};
        vecs[4]  = '{3'b100, 32'h0000_0102, 5'd8,  32'h80FF_1234, 1'b0, 32'h0000_0100, 32'h0000_00FF};
        vecs[5]  = '{3'b000, 32'h0000_0100, 5'd9,  32'h80FF_1234, 1'b0, 32'h0000_0100, 32'h0000_0034};
        vecs[6]  = '{3'b001, 32'h0000_0300, 5'd10, 32'h1234_8001, 1'b0, 32'h0000_0300, 32'hFFFF_8001};
        vecs[7]  = '{3'b010, 32'h0000_0404, 5'd31, 32'hDEAD_BEEF, 1'b0, 32'h0000_0404, 32'hDEAD_BEEF};
        vecs[8]  = '{3'b101, 32'h0000_0201, 5'd2,  32'h0,         1'b1, 32'h0,         32'h0};
        vecs[9]  = '{3'b011, 32'h0000_0000, 5'd2,  32'h0,         1'b1, 32'h0,         32'h0};
        vecs[10] = '{3'b110, 32'h0000_0010, 5'd2,  32'h0,         1'b1, 32'h0,         32'h0};
        vecs[11] = '{3'b111, 32'h0000_0020, 5'd2,  32'h0,         1'b1, 32'h0,         32'h0};
        vecs[12] = '{3'b010, 32'h0000_0002, 5'd2,  32'h0,         1'b1, 32'h0,         32'h0};
        vecs[13] = '{3'b001, 32'h0000_0005, 5'd2,  32'h0,         1'b1, 32'h0,         32'h0};
        vecs[14] = '{3'b100, 32'hFFFF_FFFF, 5'd12, 32'h7F00_0000, 1'b0, 32'hFFFF_FFFC, 32'h0000_007F};
        vecs[15] = '{3'b101, 32'h0000_0812, 5'd13, 32'hF00D_0000, 1'b0, 32'h0000_0810, 32'h0000_F00D};

        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_rd     = 5'd0;
        bus.req_funct3 = 3'b000;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        step();
        step();

        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_memreq", 32'(bus.mem_req), 32'd0);
        chk("rst_maddr", bus.mem_addr, 32'h0);
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wd3", wd3, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], i);
        end

        // grant stalled 5 cycles, LW to x0
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h0000_1008;
        bus.req_rd     = 5'd0;
        bus.req_funct3 = 3'b010;
        step();
        bus.req_valid  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stall_memreq_c%0d", i), 32'(bus.mem_req), 32'd1);
            chk($sformatf("stall_maddr_c%0d", i), bus.mem_addr, 32'h0000_1008);
            bus.mem_gnt = (i == 5);
            step();
        end
        bus.mem_gnt    = 1'b0;
        chk("stall_wait_memreq", 32'(bus.mem_req), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_1111;
        step();
        bus.mem_rvalid = 1'b0;
        chk("x0_we3", 32'(we3), 32'd0);
        chk("x0_wd3_hold", wd3, 32'h0000_F00D);
        step();
        chk("x0_idle", 32'(busy), 32'd0);
        chk("x0_we3_end", 32'(we3), 32'd0);

        // no rvalid: timeout after 16 WAIT cycles
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h0000_2000;
        bus.req_rd     = 5'd3;
        bus.req_funct3 = 3'b010;
        step();
        bus.req_valid  = 1'b0;
        bus.mem_gnt    = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("to_noerr_c%0d", i), 32'(err), 32'd0);
        end
        step();
        chk("to_err", 32'(err), 32'd1);
        chk("to_we3", 32'(we3), 32'd0);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_ready", 32'(bus.req_ready), 32'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h3333_3333;
        step();
        bus.mem_rvalid = 1'b0;
        chk("late_we3", 32'(we3), 32'd0);
        chk("late_err", 32'(err), 32'd0);
        chk("late_busy", 32'(busy), 32'd0);
        chk("late_wd3_hold", wd3, 32'h0000_F00D);

        // reset while in WAIT
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h0000_0010;
        bus.req_rd     = 5'd9;
        bus.req_funct3 = 3'b000;
        step();
        bus.req_valid  = 1'b0;
        bus.mem_gnt    = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        step();
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_memreq", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_maddr", bus.mem_addr, 32'h0);
        chk("mid_rst_waddr", 32'(waddr), 32'd0);
        chk("mid_rst_wd3", wd3, 32'h0);
        chk("mid_rst_err", 32'(err), 32'd0);
        step();
        reset          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h8080_8080;
        step();
        bus.mem_rvalid = 1'b0;
        chk("post_rst_we3", 32'(we3), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        step();
        chk("post_rst_we3_2", 32'(we3), 32'd0);

        // accepted again after reset
        run_vec(vecs[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_wb_unit.md
LOAD_WB_UNIT -- requirements
Module: load_wb_unit

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum cycles spent in WAIT before the load is abandoned; legal range 2..255.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  load request from the core.
REQ-006 req_ready  out  1  unit can accept a request.
REQ-007 req_addr  in  32  byte address of the load.
REQ-008 req_rd  in  5  destination register index.
REQ-009 req_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 mem_req  out  1  memory read request.
REQ-011 mem_addr  out  32  word-aligned read address.
REQ-012 mem_gnt  in  1  memory accepted mem_req this cycle.
REQ-013 mem_rvalid  in  1  mem_rdata valid this cycle.
REQ-014 mem_rdata  in  32  read data word.
REQ-015 waddr  out  5  register-file write index.
REQ-016 we3  out  1  register-file write enable, one-cycle pulse.
REQ-017 wd3  out  32  register-file write data.
REQ-018 err  out  1  one-cycle pulse on a rejected or timed-out load.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 The unit SHALL be a registered FSM with states IDLE, REQ, WAIT, WB; all outputs SHALL be driven from registers or state decode only.
REQ-021 In IDLE, req_ready=1; in all other states, req_ready=0.
REQ-022 A handshake (req_valid & req_ready) SHALL capture req_addr, req_rd and req_funct3.
REQ-023 On a handshake, if funct3 is illegal (011, 110, 111), or the access is misaligned (LH/LHU with addr[0]=1; LW with addr[1:0]!=00), the unit SHALL stay in IDLE, pulse err the next cycle, and issue no memory request and no write.
REQ-024 A legal handshake SHALL move the FSM to REQ on the next edge.
REQ-025 In REQ, mem_req=1 and mem_addr={addr[31:2],2'b00}, both held stable until the cycle mem_gnt=1; that edge SHALL move the FSM to WAIT.
REQ-026 On entry to WAIT, an 8-bit counter SHALL clear and then increment each cycle.
REQ-027 In WAIT, mem_rvalid=1 SHALL capture the extended data and move the FSM to WB.
REQ-028 In WAIT, if the counter reaches TIMEOUT-1 without mem_rvalid, the unit SHALL return to IDLE and pulse err, with no write.
REQ-029 mem_rvalid SHALL be ignored outside WAIT.
REQ-030 Byte select: data byte = mem_rdata[8*addr[1:0]+:8]. LB sign-extends it; LBU zero-extends it.
REQ-031 Half select: data half = mem_rdata[16*addr[1]+:16]. LH sign-extends it; LHU zero-extends it.
REQ-032 LW SHALL pass mem_rdata unchanged.
REQ-033 In WB, we3=1 for exactly one cycle with waddr=rd and wd3=the extended data; if rd=0, we3 SHALL remain 0. The FSM then returns to IDLE.
REQ-034 Latency: with mem_gnt in the first REQ cycle and mem_rvalid in the first WAIT cycle, we3 SHALL assert 3 cycles after the handshake cycle, and the next request can be accepted 4 cycles after it.
REQ-035 we3 and err SHALL never both be 1 in the same cycle; outside pulses, wd3 and waddr hold their last values.

Reset
REQ-036 reset=0 SHALL immediately force IDLE, with req_ready=1, mem_req=0, mem_addr=0, we3=0, waddr=0, wd3=0, err=0, busy=0, and the counter at 0.
REQ-037 Reset asserted mid-transaction SHALL abandon the load with no write; a mem_rvalid arriving after reset release SHALL be ignored.

Verification
REQ-038 LB: addr=0x103, mem_rdata=0x80FF_1234, rd=5 -> we3 pulse with waddr=5, wd3=0xFFFF_FF80, mem_addr=0x100.
REQ-039 LHU: addr=0x202, mem_rdata=0x9ABC_0000, rd=7 -> wd3=0x0000_9ABC. LH with the same stimulus -> wd3=0xFFFF_9ABC.
REQ-040 Misaligned LW: addr=0x0000_0006 -> err pulse, mem_req stays 0, we3 stays 0, req_ready stays 1.
REQ-041 mem_gnt held low for 5 cycles -> mem_req and mem_addr stable for 6 cycles; LW to rd=0 -> we3 never asserts and the FSM returns to IDLE.
REQ-042 No mem_rvalid with TIMEOUT=16 -> err pulses 16 cycles after WAIT entry, with no write; a late mem_rvalid is ignored.
REQ-043 reset=0 asserted in WAIT -> outputs take their reset values at once; a following mem_rvalid produces no we3.
